mc_controller: RTL and testbench

// - Multicycle ARM control unit: successor to the single-cycle control decoder.
// - Sequences each instruction through a Moore FSM (fetch/decode/execute/mem/writeback).
// - Holds the NZCV flag register; evaluates condition codes and gates PC, register and memory writes.
// - Sits between the instruction register and the shared-memory multicycle datapath.

---
 rtl/mc_controller.sv | 170 +++++++++++++++++
 tb/tb_mc_controller.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// Multicycle ARM control unit: Moore FSM sequencer, NZCV flag register and condition gating.
// Optional macro MC_CMP_TST_EN makes CMP/TST legal (flag-only data-processing ops).
module mc_controller #(
    parameter int ALU_CTRL_W = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            Cond,
    input  logic [1:0]            Op,
    input  logic [5:0]            Funct,
    input  logic [3:0]            Rd,
    input  logic [3:0]            ALUFlags,
    output logic                  PCWrite,
    output logic                  AdrSrc,
    output logic                  MemWrite,
    output logic                  IRWrite,
    output logic                  RegWrite,
    output logic [1:0]            ResultSrc,
    output logic [1:0]            ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [1:0]            ImmSrc,
    output logic [1:0]            RegSrc,
    output logic [ALU_CTRL_W-1:0] ALUControl,
    output logic [3:0]            Flags,
    output logic [3:0]            State,
    output logic                  Undef
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD  = 4'd3, MEMWB  = 4'd4,
        MEMWR  = 4'd5, EXECR  = 4'd6, EXECI  = 4'd7, ALUWB  = 4'd8, BRANCH = 4'd9
    } state_t;

    state_t                state, state_next;
    logic   [3:0]          flags_q;
    logic                  cond_ex, cond_ex_r;
    logic [ALU_CTRL_W-1:0] alu_op;
    logic                  cmd_ok, arith, no_write;
    logic                  undef_instr, set_s;

    // Data-processing command decode; CMP/TST reuse SUB/AND but suppress the writeback.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        alu_op   = '0;
        cmd_ok   = 1'b1;
        arith    = 1'b0;
        no_write = 1'b0;
        case (Funct[4:1])
            4'b0100: begin alu_op = ALU_CTRL_W'(0); arith = 1'b1; end
            4'b0010: begin alu_op = ALU_CTRL_W'(1); arith = 1'b1; end
            4'b0000: alu_op = ALU_CTRL_W'(2);
            4'b1100: alu_op = ALU_CTRL_W'(3);
            4'b0001: begin alu_op = ALU_CTRL_W'(4); cmd_ok = (ALU_CTRL_W == 3); end
`ifdef MC_CMP_TST_EN
            4'b1010: begin alu_op = ALU_CTRL_W'(1); arith = 1'b1; no_write = 1'b1; end
            4'b1000: begin alu_op = ALU_CTRL_W'(2); no_write = 1'b1; end
`endif
            default: cmd_ok = 1'b0;
        endcase
    end

    assign undef_instr = (Op == 2'b11) || ((Op == 2'b00) && !cmd_ok);
    assign set_s       = Funct[0] || no_write;

    always_comb begin
        cond_ex = 1'b1;
        case (Cond)
            4'b0000: cond_ex = flags_q[2];
            4'b0001: cond_ex = !flags_q[2];
            4'b0010: cond_ex = flags_q[1];
            4'b0011: cond_ex = !flags_q[1];
            4'b0100: cond_ex = flags_q[3];
            4'b0101: cond_ex = !flags_q[3];
            4'b0110: cond_ex = flags_q[0];
            4'b0111: cond_ex = !flags_q[0];
            4'b1000: cond_ex = flags_q[1] && !flags_q[2];
            4'b1001: cond_ex = !flags_q[1] || flags_q[2];
            4'b1010: cond_ex = (flags_q[3] == flags_q[0]);
            4'b1011: cond_ex = (flags_q[3] != flags_q[0]);
            4'b1100: cond_ex = !flags_q[2] && (flags_q[3] == flags_q[0]);
            4'b1101: cond_ex = flags_q[2] || (flags_q[3] != flags_q[0]);
            default: cond_ex = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= state_next;
    end

    // Condition is frozen at the end of DECODE; flags only change when a conditional S-op retires.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q   <= 4'b0000;
            cond_ex_r <= 1'b0;
        end else begin
            if (state == DECODE) cond_ex_r <= cond_ex;
            if ((state == EXECR || state == EXECI) && cond_ex_r && set_s) begin
                flags_q[3:2] <= ALUFlags[3:2];
                if (arith) flags_q[1:0] <= ALUFlags[1:0];
            end
        end
    end

    always_comb begin
        state_next = FETCH;
        case (state)
            FETCH:  state_next = DECODE;
            DECODE: begin
                if (undef_instr)        state_next = FETCH;
                else if (Op == 2'b01)   state_next = MEMADR;
                else if (Op == 2'b10)   state_next = BRANCH;
                else if (Funct[5])      state_next = EXECI;
                else                    state_next = EXECR;
            end
            MEMADR: state_next = Funct[0] ? MEMRD : MEMWR;
            MEMRD:  state_next = MEMWB;
            EXECR, EXECI: state_next = no_write ? FETCH : ALUWB;
            default: state_next = FETCH;
        endcase
    end

    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = '0;
        Undef      = 1'b0;
        case (state)
            FETCH: begin
                IRWrite = 1'b1; PCWrite = 1'b1;
                ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
            end
            DECODE: begin
                ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
                Undef   = undef_instr;
            end
            MEMADR: ALUSrcB = 2'b01;
            MEMRD:  AdrSrc = 1'b1;
            MEMWR:  begin AdrSrc = 1'b1; MemWrite = cond_ex_r; end
            MEMWB:  begin
                ResultSrc = 2'b01; RegWrite = cond_ex_r;
                PCWrite   = cond_ex_r && (Rd == 4'd15);
            end
            EXECR:  ALUControl = alu_op;
            EXECI:  begin ALUSrcB = 2'b01; ALUControl = alu_op; end
            ALUWB:  begin
                RegWrite = cond_ex_r;
                PCWrite  = cond_ex_r && (Rd == 4'd15);
            end
            BRANCH: begin
                ALUSrcA = 2'b10; ALUSrcB = 2'b01; ResultSrc = 2'b10;
                PCWrite = cond_ex_r;
            end
            default: ;
        endcase
    end

    assign ImmSrc = Op;
    assign RegSrc = {Op == 2'b01, Op == 2'b10};
    assign Flags  = flags_q;
    assign State  = state;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed instruction table, a reset-in-MEMWR sequence,
// then random instructions against an instruction-level reference model.
`timescale 1ns/1ps
module tb_mc_controller;
    localparam int AW = 2;
`ifdef MC_CMP_TST_EN
    localparam bit CMP_TST = 1'b1;
`else
    localparam bit CMP_TST = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    Cond, Rd, ALUFlags;
    logic [1:0]    Op;
    logic [5:0]    Funct;
    logic          PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Undef;
    logic [1:0]    ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc;
    logic [AW-1:0] ALUControl;
    logic [3:0]    Flags, State;

    mc_controller #(.ALU_CTRL_W(AW)) dut (
        .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
        .ALUFlags(ALUFlags), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
        .Flags(Flags), .State(State), .Undef(Undef)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [3:0] mflags;

    typedef struct packed {
        logic       pcw, adrsrc, memw, irw, regw;
        logic [1:0] ressrc, asa, asb, imm, regsrc;
        logic [2:0] aluc;
        logic       undef;
    } outs_t;

    typedef struct packed {
        logic       legal, arith, nowrite;
        logic [2:0] code;
    } dp_t;

    typedef struct {
        logic [3:0] cond;
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] rd;
        logic [3:0] af;
        int         cpi;
        logic [3:0] flags;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ARM condition table over {N,Z,C,V}
    function automatic bit cond_holds(logic [3:0] c, logic [3:0] f);
        bit n = f[3], z = f[2], cy = f[1], v = f[0];
        case (c)
            4'h0: return z;          4'h1: return !z;
            4'h2: return cy;         4'h3: return !cy;
            4'h4: return n;          4'h5: return !n;
            4'h6: return v;          4'h7: return !v;
            4'h8: return cy && !z;   4'h9: return !cy || z;
            4'hA: return n == v;     4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    function automatic dp_t dp_info(logic [3:0] cmd);
        dp_t d = '{legal: 1'b1, arith: 1'b0, nowrite: 1'b0, code: 3'd0};
        case (cmd)
            4'b0100: begin d.code = 3'd0; d.arith = 1'b1; end
            4'b0010: begin d.code = 3'd1; d.arith = 1'b1; end
            4'b0000: d.code = 3'd2;
            4'b1100: d.code = 3'd3;
            4'b0001: begin d.code = 3'd4; d.legal = (AW == 3); end
            4'b1010: begin d.code = 3'd1; d.arith = 1'b1; d.nowrite = 1'b1; d.legal = CMP_TST; end
            4'b1000: begin d.code = 3'd2; d.nowrite = 1'b1; d.legal = CMP_TST; end
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

    function automatic outs_t expect_outs(int s, bit ok, logic [1:0] op, logic [5:0] funct, logic [3:0] rd);
        outs_t o = '0;
        dp_t   d = dp_info(funct[4:1]);
        o.imm    = op;
        o.regsrc = {op == 2'b01, op == 2'b10};
        case (s)
            0: begin o.irw = 1; o.pcw = 1; o.asa = 2'b01; o.asb = 2'b10; o.ressrc = 2'b10; end
            1: begin
                o.asa = 2'b01; o.asb = 2'b10; o.ressrc = 2'b10;
                o.undef = (op == 2'b11) || (op == 2'b00 && !d.legal);
            end
            2: o.asb = 2'b01;
            3: o.adrsrc = 1;
            4: begin o.ressrc = 2'b01; o.regw = ok; o.pcw = ok && rd == 4'd15; end
            5: begin o.adrsrc = 1; o.memw = ok; end
            6: o.aluc = d.code;
            7: begin o.asb = 2'b01; o.aluc = d.code; end
            8: begin o.regw = ok; o.pcw = ok && rd == 4'd15; end
            9: begin o.asa = 2'b10; o.asb = 2'b01; o.ressrc = 2'b10; o.pcw = ok; end
            default: ;
        endcase
        return o;
    endfunction

    // Runs one instruction from FETCH until the DUT returns to FETCH, checking every cycle.
    task automatic run_instr(input logic [3:0] c, input logic [1:0] op, input logic [5:0] funct,
                             input logic [3:0] rd, input logic [3:0] af, output int cycles);
        int    trace[$];
        dp_t   d  = dp_info(funct[4:1]);
        bit    ok = cond_holds(c, mflags);
        int    n  = 0;
        int    s;
        outs_t act, exp;
        trace = '{0, 1};
        if (op == 2'b01)      trace = funct[0] ? '{0, 1, 2, 3, 4} : '{0, 1, 2, 5};
        else if (op == 2'b10) trace = '{0, 1, 9};
        else if (op == 2'b00 && d.legal) begin
            trace.push_back(funct[5] ? 7 : 6);
            if (!d.nowrite) trace.push_back(8);
        end
        Cond = c; Op = op; Funct = funct; Rd = rd;
        do begin
            s = (n < trace.size()) ? trace[n] : -1;
            ALUFlags = (s == 6 || s == 7) ? af : 4'($urandom);
            #1;
            check("state", 32'(State), 32'(s));
            if (s >= 0) begin
                act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
                       ALUSrcB, ImmSrc, RegSrc, 3'(ALUControl), Undef};
                exp = expect_outs(s, ok, op, funct, rd);
                check($sformatf("outs_s%0d", s), 32'(act), 32'(exp));
            end
            @(posedge clk); #1;
            if ((s == 6 || s == 7) && ok && (funct[0] || d.nowrite)) begin
                mflags[3:2] = af[3:2];
                if (d.arith) mflags[1:0] = af[1:0];
            end
            n++;
        end while (State != 4'd0 && n < 8);
        if (State != 4'd0) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout: state %0d never returned to FETCH", State);
        end
        check("cpi", 32'(n), 32'(trace.size()));
        check("flags", 32'(Flags), 32'(mflags));
        cycles = n;
    endtask

    vec_t vecs[13];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        vecs[0]  = '{4'hE, 2'b01, 6'h19, 4'd2,  4'h0, 5, 4'b0000};  // LDR
        vecs[1]  = '{4'hE, 2'b01, 6'h18, 4'd3,  4'h0, 4, 4'b0000};  // STR
        vecs[2]  = '{4'hE, 2'b00, 6'h09, 4'd1,  4'h9, 4, 4'b1001};  // ADDS overflow
        vecs[3]  = '{4'h0, 2'b10, 6'h20, 4'd0,  4'h0, 3, 4'b1001};  // BEQ not taken
        vecs[4]  = '{4'hE, 2'b00, 6'h21, 4'd4,  4'h6, 4, 4'b0101};  // ANDS imm
        vecs[5]  = '{4'h0, 2'b10, 6'h20, 4'd0,  4'h0, 3, 4'b0101};  // BEQ taken
        vecs[6]  = '{4'h1, 2'b00, 6'h05, 4'd5,  4'hF, 4, 4'b0101};  // SUBSNE skipped
        vecs[7]  = '{4'hE, 2'b00, 6'h03, 4'd6,  4'hF, 2, 4'b0101};  // EOR, undef at width 2
        vecs[8]  = '{4'hE, 2'b11, 6'h3F, 4'd7,  4'hF, 2, 4'b0101};  // Op=11
        vecs[9]  = '{4'hE, 2'b00, 6'h19, 4'd8,  4'h8, 4, 4'b1001};  // ORRS
        vecs[10] = '{4'hE, 2'b00, 6'h15, 4'd0,  4'h6, CMP_TST ? 3 : 2,
                     CMP_TST ? 4'b0110 : 4'b1001};                  // CMP
        vecs[11] = '{4'hE, 2'b00, 6'h08, 4'd15, 4'hF, 4,
                     CMP_TST ? 4'b0110 : 4'b1001};                  // ADD to PC
        vecs[12] = '{4'hE, 2'b00, 6'h11, 4'd0,  4'hC, CMP_TST ? 3 : 2,
                     CMP_TST ? 4'b1110 : 4'b1001};                  // TST

        reset = 1'b1; Cond = 4'hE; Op = 2'b00; Funct = 6'h00; Rd = 4'd0; ALUFlags = 4'h0;
        mflags = 4'b0000;
        #3;
        check("rst_state", 32'(State), 32'd0);
        check("rst_pcwrite", 32'(PCWrite), 32'd1);
        check("rst_irwrite", 32'(IRWrite), 32'd1);
        check("rst_flags", 32'(Flags), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        foreach (vecs[i]) begin
            run_instr(vecs[i].cond, vecs[i].op, vecs[i].funct, vecs[i].rd, vecs[i].af, cyc);
            check($sformatf("vec%0d_cpi", i), 32'(cyc), 32'(vecs[i].cpi));
            check($sformatf("vec%0d_flags", i), 32'(Flags), 32'(vecs[i].flags));
        end

        // Reset asserted in the middle of a store's MEMWR cycle
        Cond = 4'hE; Op = 2'b01; Funct = 6'h18; Rd = 4'd3; ALUFlags = 4'h0;
        repeat (3) begin @(posedge clk); #1; end
        check("memwr_state", 32'(State), 32'd5);
        check("memwr_strobe", 32'(MemWrite), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("midrst_state", 32'(State), 32'd0);
        check("midrst_memwrite", 32'(MemWrite), 32'd0);
        check("midrst_flags", 32'(Flags), 32'd0);
        check("midrst_pcwrite", 32'(PCWrite), 32'd1);
        @(posedge clk); #1;
        check("midrst_hold", 32'(State), 32'd0);
        reset = 1'b0;
        mflags = 4'b0000;

        for (int k = 0; k < 400; k++) begin
            logic [5:0] f;
            logic [3:0] cmds[6] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010, 4'b1000};
            f = 6'($urandom);
            if ($urandom_range(0, 1) == 1) f[4:1] = cmds[$urandom_range(0, 5)];
            run_instr(4'($urandom), 2'($urandom), f,
                      ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom), 4'($urandom), cyc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
